if_stage: RTL
=============

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the decode stage.
//  Holds the PC and fetches from instruction memory over a req/ack handshake.
//  Applies decode-stage redirects (branch/jump/jr) and stalls (PC_IFWrite).
//  Presents Instruction_id / NextPC_id to decode; flushes to NOP on redirect.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0000  instruction injected on flush/bubble (sll $0,$0,0)
// PORTS
//  clk           in   1   system clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  PC_IFWrite    in   1   1 = advance PC and IF/ID; 0 = hold both (load-use stall)
//  Z             in   1   conditional branch taken (from decode)
//  J             in   1   jump (from decode)
//  JR            in   1   jump-register (from decode)
//  BranchAddr    in   32  branch target
//  JumpAddr      in   32  jump target
//  JrAddr        in   32  jump-register target
//  imem_req      out  1   fetch request; held until imem_ack
//  imem_addr     out  32  fetch address (= PC); stable while imem_req=1
//  imem_ack      in   1   fetch data valid this cycle (same-cycle ack allowed)
//  imem_rdata    in   32  fetched instruction
//  Instruction_id out 32  IF/ID instruction
//  NextPC_id     out 32  IF/ID PC+4 of that instruction
// BEHAVIOUR
//  Reset: PC=RESET_PC, state=S_IDLE, imem_req=0, Instruction_id=NOP_INSTR, NextPC_id=RESET_PC+4, buffer empty.
//  redirect = PC_IFWrite & (JR|J|Z); target priority JR > J > Z; target[1:0] forced to 2'b00.
//  Stall priority: PC_IFWrite=0 masks redirect entirely; PC and IF/ID hold.
//  FSM:
//   S_IDLE: one cycle after reset release; -> S_REQ.
//   S_REQ: imem_req=1, imem_addr=PC. Per cycle:
//    - redirect: IF/ID<=NOP; PC<=target; if ack, data dropped; if no ack, set drop_pending; stay S_REQ.
//    - ack & drop_pending: data dropped, clear drop_pending, re-issue at current PC.
//    - ack & PC_IFWrite: IF/ID<={imem_rdata, PC+4}; PC<=PC+4; stay S_REQ (1 instr/cycle at zero-wait).
//    - ack & !PC_IFWrite: capture imem_rdata in skid buffer; -> S_HOLD.
//    - no ack & PC_IFWrite: IF/ID<=NOP bubble, NextPC_id<=PC+4.
//   S_HOLD: imem_req=0. PC_IFWrite=1 & !redirect: IF/ID<=buffer, PC<=PC+4, -> S_REQ.
//    redirect: buffer discarded, IF/ID<=NOP, PC<=target, -> S_REQ.
//  imem_addr must not change while imem_req=1 and no ack, except on redirect with drop_pending (address
//   updates once the outstanding ack returns).
//  PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
//  Reset mid-transaction: req drops immediately (async); outstanding ack after reset is ignored.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs fetch_cnt[31:0] (instrs delivered to IF/ID, non-NOP-injected)
//   and flush_cnt[31:0] (redirects applied); both reset to 0, wrap at 2^32.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Zero-wait ack, no stall, 4 cycles -> imem_addr 0,4,8,C; NextPC_id 4,8,C,10 one cycle later.
//  Ack held low 3 cycles at PC=8 -> imem_addr=8 stable, 3 NOP bubbles, then instr with NextPC_id=C.
//  PC_IFWrite=0 on ack cycle -> S_HOLD, IF/ID unchanged; release -> buffered instr issued, PC advances by 4.
//  Z=1,BranchAddr=0x40 with J=1,JumpAddr=0x80 -> PC=0x80, Instruction_id=NOP next cycle.
//  Redirect to 0x100 while req outstanding at 0x20, ack 2 cycles later -> data dropped, next addr 0x100.
//  IF_PERF_CNT_EN: 10 fetches, 2 redirects -> fetch_cnt=8 or per delivered count, flush_cnt=2.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory fetch handshake: if_stage is the master, the instruction memory the slave.
// req is held until ack; addr is stable while req=1 and no ack has returned.
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, decode redirects, stalls and a one-word skid buffer.
// Optional performance counters (fetch_cnt, flush_cnt) are built when IF_PERF_CNT_EN is defined.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_IFWrite,
    input  logic        Z,
    input  logic        J,
    input  logic        JR,
    input  logic [31:0] BranchAddr,
    input  logic [31:0] JumpAddr,
    input  logic [31:0] JrAddr,
    if_stage_if.master  imem,
    output logic [31:0] Instruction_id,
    output logic [31:0] NextPC_id
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] skid_q, skid_d;
    logic        drop_q, drop_d;
    logic [31:0] hold_addr_q, hold_addr_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // A stall masks the redirect completely; JR wins over J, J over Z.
    always_comb begin
        redirect = PC_IFWrite & (JR | J | Z);
        if (JR) begin
            target = JrAddr;
        end else if (J) begin
            target = JumpAddr;
        end else begin
            target = BranchAddr;
        end
        target[1:0] = 2'b00;
        pc_plus4    = pc_q + 32'd4;
    end

    // While a dropped request is still outstanding, keep presenting its address.
    assign imem.req       = (state_q == S_REQ);
    assign imem.addr      = drop_q ? hold_addr_q : pc_q;
    assign Instruction_id = instr_q;
    assign NextPC_id      = npc_q;

    // NOTE: every _d signal gets its hold value first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        npc_d       = npc_q;
        skid_d      = skid_q;
        drop_d      = drop_q;
        hold_addr_d = hold_addr_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                if (redirect) begin
                    instr_d = NOP_INSTR;
                    npc_d   = pc_plus4;
                    pc_d    = target;
                    if (imem.ack) begin
                        drop_d = 1'b0;
                    end else begin
                        if (!drop_q) begin
                            hold_addr_d = pc_q;
                        end
                        drop_d = 1'b1;
                    end
                end else if (imem.ack && drop_q) begin
                    drop_d = 1'b0;
                    if (PC_IFWrite) begin
                        instr_d = NOP_INSTR;
                        npc_d   = pc_plus4;
                    end
                end else if (imem.ack && PC_IFWrite) begin
                    instr_d = imem.rdata;
                    npc_d   = pc_plus4;
                    pc_d    = pc_plus4;
                end else if (imem.ack) begin
                    skid_d  = imem.rdata;
                    state_d = S_HOLD;
                end else if (PC_IFWrite) begin
                    instr_d = NOP_INSTR;
                    npc_d   = pc_plus4;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    instr_d = NOP_INSTR;
                    npc_d   = pc_plus4;
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (PC_IFWrite) begin
                    instr_d = skid_q;
                    npc_d   = pc_plus4;
                    pc_d    = pc_plus4;
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: the state register uses non-blocking assignments only; all next-state math stays in always_comb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            npc_q       <= RESET_PC + 32'd4;
            skid_q      <= NOP_INSTR;
            drop_q      <= 1'b0;
            hold_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            npc_q       <= npc_d;
            skid_q      <= skid_d;
            drop_q      <= drop_d;
            hold_addr_q <= hold_addr_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic        fetch_evt;
    logic        flush_evt;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // A fetch counts only when a real instruction lands in IF/ID, never for an injected NOP.
    always_comb begin
        flush_evt = (state_q != S_IDLE) && redirect;
        fetch_evt = ((state_q == S_REQ) && !redirect && imem.ack && !drop_q && PC_IFWrite)
                 || ((state_q == S_HOLD) && !redirect && PC_IFWrite);
        fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_evt};
        flush_cnt_d = flush_cnt_q + {31'd0, flush_evt};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
